// File: rtl/ula_sequencer.sv
// ula_sequencer
//
// Control FSM that sequences the 8-bit ULA of the switch-driven processor.
// Operand A, operand B and the opcode are captured from the shared switch
// bus on three successive load strobes, then a single-cycle start is issued
// to the ULA. The sequencer waits for the ULA done pulse, latches the result
// for display, and exposes its state encoding for LED debug.
//
// Ports:
//   clock         in   system clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   data_in[7:0]  in   operand/opcode value from the switches
//   load          in   single-cycle load strobe (debounced, edge-detected)
//   abort         in   single-cycle abort strobe, returns to IDLE
//   ula_done      in   ULA result-ready pulse
//   ula_result    in   ULA result, valid while ula_done=1
//   reg_a[7:0]    out  operand A to ULA
//   reg_b[7:0]    out  operand B to ULA
//   opcode[7:0]   out  opcode to ULA
//   ula_start     out  one-cycle start pulse to ULA
//   result[7:0]   out  latched ULA result
//   result_valid  out  result holds a completed operation
//   busy          out  high while in START or WAIT
//   state[2:0]    out  current FSM encoding, for LEDR
//   error         out  timeout flag
//
// Configuration:
//   ULA_SEQ_TIMEOUT_EN  when defined, a watchdog counts WAIT cycles without
//                       ula_done and enters ERR once TIMEOUT_CYCLES is
//                       reached. When undefined, WAIT waits forever, ERR is
//                       unreachable, error is tied to 0 and TIMEOUT_CYCLES
//                       is unused.

module ula_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 200
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] data_in,
    input  logic       load,
    input  logic       abort,
    input  logic       ula_done,
    input  logic [7:0] ula_result,
    output logic [7:0] reg_a,
    output logic [7:0] reg_b,
    output logic [7:0] opcode,
    output logic       ula_start,
    output logic [7:0] result,
    output logic       result_valid,
    output logic       busy,
    output logic [2:0] state,
    output logic       error
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GET_B  = 3'd1,
        ST_GET_OP = 3'd2,
        ST_START  = 3'd3,
        ST_WAIT   = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] reg_a_q, reg_a_d;
    logic [7:0] reg_b_q, reg_b_d;
    logic [7:0] opcode_q, opcode_d;
    logic [7:0] result_q, result_d;
    logic       result_valid_q, result_valid_d;

`ifdef ULA_SEQ_TIMEOUT_EN
    // The counter holds the number of WAIT cycles already spent without
    // ula_done, so the cycle in which it equals TIMEOUT_CYCLES-1 is the
    // TIMEOUT_CYCLES-th WAIT cycle and is the last chance for done to win.
    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] count_q, count_d;
`else
    logic [7:0] timeout_unused;
    assign timeout_unused = 8'(TIMEOUT_CYCLES);
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            reg_a_q        <= 8'h00;
            reg_b_q        <= 8'h00;
            opcode_q       <= 8'h00;
            result_q       <= 8'h00;
            result_valid_q <= 1'b0;
`ifdef ULA_SEQ_TIMEOUT_EN
            count_q        <= 8'h00;
`endif
        end else begin
            state_q        <= state_d;
            reg_a_q        <= reg_a_d;
            reg_b_q        <= reg_b_d;
            opcode_q       <= opcode_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
`ifdef ULA_SEQ_TIMEOUT_EN
            count_q        <= count_d;
`endif
        end
    end

    // Abort overrides every state and every other input, including a load or
    // a ula_done in the same cycle; captured operands and result are kept.
    always_comb begin
        state_d        = state_q;
        reg_a_d        = reg_a_q;
        reg_b_d        = reg_b_q;
        opcode_d       = opcode_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
`ifdef ULA_SEQ_TIMEOUT_EN
        count_d        = count_q;
`endif

        if (abort) begin
            state_d        = ST_IDLE;
            result_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (load) begin
                        reg_a_d = data_in;
                        state_d = ST_GET_B;
                    end
                end
                ST_GET_B: begin
                    if (load) begin
                        reg_b_d = data_in;
                        state_d = ST_GET_OP;
                    end
                end
                ST_GET_OP: begin
                    if (load) begin
                        opcode_d = data_in;
                        state_d  = ST_START;
                    end
                end
                ST_START: begin
                    state_d = ST_WAIT;
`ifdef ULA_SEQ_TIMEOUT_EN
                    count_d = 8'h00;
`endif
                end
                ST_WAIT: begin
                    if (ula_done) begin
                        result_d       = ula_result;
                        result_valid_d = 1'b1;
                        state_d        = ST_DONE;
                    end
`ifdef ULA_SEQ_TIMEOUT_EN
                    else if (count_q == LAST_COUNT) begin
                        state_d = ST_ERR;
                    end else begin
                        count_d = count_q + 8'd1;
                    end
`endif
                end
                ST_DONE: begin
                    // A load here starts the next operation directly.
                    if (load) begin
                        reg_a_d        = data_in;
                        result_valid_d = 1'b0;
                        state_d        = ST_GET_B;
                    end
                end
                ST_ERR: begin
`ifdef ULA_SEQ_TIMEOUT_EN
                    if (load) begin
                        state_d = ST_IDLE;
                    end
`else
                    state_d = ST_IDLE;
`endif
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign reg_a        = reg_a_q;
    assign reg_b        = reg_b_q;
    assign opcode       = opcode_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign state        = state_q;
    assign ula_start    = (state_q == ST_START);
    assign busy         = (state_q == ST_START) || (state_q == ST_WAIT);

`ifdef ULA_SEQ_TIMEOUT_EN
    assign error = (state_q == ST_ERR);
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_ula_sequencer.sv
// tb_ula_sequencer
//
// Self-checking bench for ula_sequencer. The reference model tracks what the
// sequencer should hold at the operation level (captured operands, latched
// result, valid flag and the phase of the current operation); the expected
// busy/start/error outputs follow from that phase.

module tb_ula_sequencer;

    localparam int TO = 4;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       load = 1'b0;
    logic       abort = 1'b0;
    logic       ula_done = 1'b0;
    logic [7:0] ula_result = 8'h00;
    logic [7:0] reg_a;
    logic [7:0] reg_b;
    logic [7:0] opcode;
    logic       ula_start;
    logic [7:0] result;
    logic       result_valid;
    logic       busy;
    logic [2:0] state;
    logic       error;

    int vectors = 0;
    int miscompares = 0;
    int startCount = 0;

    logic [7:0] mA = 8'h00;
    logic [7:0] mB = 8'h00;
    logic [7:0] mOp = 8'h00;
    logic [7:0] mRes = 8'h00;
    logic       mValid = 1'b0;

    ula_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .data_in(data_in),
        .load(load),
        .abort(abort),
        .ula_done(ula_done),
        .ula_result(ula_result),
        .reg_a(reg_a),
        .reg_b(reg_b),
        .opcode(opcode),
        .ula_start(ula_start),
        .result(result),
        .result_valid(result_valid),
        .busy(busy),
        .state(state),
        .error(error)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (ula_start === 1'b1) startCount++;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] simulation time limit");
    end

    function automatic logic [38:0] obsVec();
        return {state, reg_a, reg_b, opcode, result, result_valid, busy, ula_start, error};
    endfunction

    function automatic logic [38:0] expVec(input logic [2:0] st);
        return {st, mA, mB, mOp, mRes, mValid,
                (st == 3'd3) || (st == 3'd4), st == 3'd3, st == 3'd6};
    endfunction

    task automatic drive(input logic ld, input logic [7:0] d, input logic ab,
                         input logic dn, input logic [7:0] r);
        load = ld;
        data_in = d;
        abort = ab;
        ula_done = dn;
        ula_result = r;
        @(posedge clock);
        #1;
        load = 1'b0;
        abort = 1'b0;
        ula_done = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        if (obsVec() !== expVec(3'd0)) begin
            miscompares++;
            $display("[TB] FAIL reset_hold got=%h want=%h", obsVec(), expVec(3'd0));
        end
        vectors++;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        drive(0, 8'h5A, 0, 0, 8'h00);
        if (obsVec() !== expVec(3'd0)) begin
            miscompares++;
            $display("[TB] FAIL reset_release got=%h want=%h", obsVec(), expVec(3'd0));
        end
        vectors++;
    endtask

    task automatic test_normal_op();
        int s0;
        drive(1, 8'h12, 0, 0, 8'h00);
        mA = 8'h12; mValid = 1'b0;
        if (obsVec() !== expVec(3'd1)) begin
            miscompares++;
            $display("[TB] FAIL normal_load_a got=%h want=%h", obsVec(), expVec(3'd1));
        end
        vectors++;
        drive(1, 8'h34, 0, 0, 8'h00);
        mB = 8'h34;
        if (obsVec() !== expVec(3'd2)) begin
            miscompares++;
            $display("[TB] FAIL normal_load_b got=%h want=%h", obsVec(), expVec(3'd2));
        end
        vectors++;
        drive(1, 8'h01, 0, 0, 8'h00);
        mOp = 8'h01;
        s0 = startCount;
        if (obsVec() !== expVec(3'd3)) begin
            miscompares++;
            $display("[TB] FAIL normal_start got=%h want=%h", obsVec(), expVec(3'd3));
        end
        vectors++;
        drive(0, 8'h00, 0, 0, 8'h00);
        if (obsVec() !== expVec(3'd4)) begin
            miscompares++;
            $display("[TB] FAIL normal_wait1 got=%h want=%h", obsVec(), expVec(3'd4));
        end
        vectors++;
        drive(0, 8'h00, 0, 0, 8'h00);
        if (obsVec() !== expVec(3'd4)) begin
            miscompares++;
            $display("[TB] FAIL normal_wait2 got=%h want=%h", obsVec(), expVec(3'd4));
        end
        vectors++;
        drive(0, 8'h00, 0, 1, 8'h46);
        mRes = 8'h46; mValid = 1'b1;
        if (obsVec() !== expVec(3'd5)) begin
            miscompares++;
            $display("[TB] FAIL normal_done got=%h want=%h", obsVec(), expVec(3'd5));
        end
        vectors++;
        if (startCount - s0 !== 1) begin
            miscompares++;
            $display("[TB] FAIL normal_start_pulses got=%0d want=1", startCount - s0);
        end
        vectors++;
    endtask

    task automatic test_chaining();
        drive(1, 8'h05, 0, 0, 8'h00);
        mA = 8'h05; mValid = 1'b0;
        if (obsVec() !== expVec(3'd1)) begin
            miscompares++;
            $display("[TB] FAIL chain_load_a got=%h want=%h", obsVec(), expVec(3'd1));
        end
        vectors++;
        drive(1, 8'h66, 0, 0, 8'h00);
        mB = 8'h66;
        drive(1, 8'h02, 0, 0, 8'h00);
        mOp = 8'h02;
        drive(1, 8'hEE, 0, 0, 8'h00);
        if (obsVec() !== expVec(3'd4)) begin
            miscompares++;
            $display("[TB] FAIL chain_load_in_start got=%h want=%h", obsVec(), expVec(3'd4));
        end
        vectors++;
        drive(1, 8'hDD, 0, 0, 8'h00);
        if (obsVec() !== expVec(3'd4)) begin
            miscompares++;
            $display("[TB] FAIL chain_load_in_wait got=%h want=%h", obsVec(), expVec(3'd4));
        end
        vectors++;
        drive(1, 8'hCC, 0, 1, 8'h68);
        mRes = 8'h68; mValid = 1'b1;
        if (obsVec() !== expVec(3'd5)) begin
            miscompares++;
            $display("[TB] FAIL chain_done got=%h want=%h", obsVec(), expVec(3'd5));
        end
        vectors++;
    endtask

    task automatic test_abort();
        drive(1, 8'h21, 0, 0, 8'h00);
        mA = 8'h21; mValid = 1'b0;
        drive(1, 8'h43, 0, 0, 8'h00);
        mB = 8'h43;
        drive(1, 8'hFF, 1, 0, 8'h00);
        if (obsVec() !== expVec(3'd0)) begin
            miscompares++;
            $display("[TB] FAIL abort_beats_load got=%h want=%h", obsVec(), expVec(3'd0));
        end
        vectors++;
        drive(1, 8'h10, 0, 0, 8'h00);
        mA = 8'h10;
        drive(1, 8'h20, 0, 0, 8'h00);
        mB = 8'h20;
        drive(1, 8'h30, 0, 0, 8'h00);
        mOp = 8'h30;
        drive(0, 8'h00, 0, 0, 8'h00);
        drive(0, 8'h00, 1, 1, 8'h99);
        if (obsVec() !== expVec(3'd0)) begin
            miscompares++;
            $display("[TB] FAIL abort_beats_done got=%h want=%h", obsVec(), expVec(3'd0));
        end
        vectors++;
    endtask

    task automatic test_spurious_done();
        drive(0, 8'h00, 0, 1, 8'hAA);
        if (obsVec() !== expVec(3'd0)) begin
            miscompares++;
            $display("[TB] FAIL spurious_idle got=%h want=%h", obsVec(), expVec(3'd0));
        end
        vectors++;
        drive(1, 8'h01, 0, 0, 8'h00);
        mA = 8'h01;
        drive(1, 8'h02, 0, 0, 8'h00);
        mB = 8'h02;
        drive(1, 8'h03, 0, 0, 8'h00);
        mOp = 8'h03;
        drive(0, 8'h00, 0, 0, 8'h00);
        drive(0, 8'h00, 0, 1, 8'h55);
        mRes = 8'h55; mValid = 1'b1;
        drive(0, 8'h00, 0, 1, 8'hAA);
        if (obsVec() !== expVec(3'd5)) begin
            miscompares++;
            $display("[TB] FAIL spurious_done_state got=%h want=%h", obsVec(), expVec(3'd5));
        end
        vectors++;
    endtask

`ifdef ULA_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        drive(1, 8'h0A, 0, 0, 8'h00);
        mA = 8'h0A; mValid = 1'b0;
        drive(1, 8'h0B, 0, 0, 8'h00);
        mB = 8'h0B;
        drive(1, 8'h0C, 0, 0, 8'h00);
        mOp = 8'h0C;
        drive(0, 8'h00, 0, 0, 8'h00);
        for (int i = 1; i < TO; i++) begin
            drive(0, 8'h00, 0, 0, 8'h00);
            if (obsVec() !== expVec(3'd4)) begin
                miscompares++;
                $display("[TB] FAIL timeout_wait%0d got=%h want=%h", i + 1, obsVec(), expVec(3'd4));
            end
            vectors++;
        end
        drive(0, 8'h00, 0, 0, 8'h00);
        if (obsVec() !== expVec(3'd6)) begin
            miscompares++;
            $display("[TB] FAIL timeout_err got=%h want=%h", obsVec(), expVec(3'd6));
        end
        vectors++;
        drive(1, 8'h77, 0, 0, 8'h00);
        if (obsVec() !== expVec(3'd0)) begin
            miscompares++;
            $display("[TB] FAIL timeout_recover got=%h want=%h", obsVec(), expVec(3'd0));
        end
        vectors++;
        drive(1, 8'h0D, 0, 0, 8'h00);
        mA = 8'h0D;
        drive(1, 8'h0E, 0, 0, 8'h00);
        mB = 8'h0E;
        drive(1, 8'h0F, 0, 0, 8'h00);
        mOp = 8'h0F;
        drive(0, 8'h00, 0, 0, 8'h00);
        for (int i = 1; i < TO; i++) drive(0, 8'h00, 0, 0, 8'h00);
        drive(0, 8'h00, 0, 1, 8'h3C);
        mRes = 8'h3C; mValid = 1'b1;
        if (obsVec() !== expVec(3'd5)) begin
            miscompares++;
            $display("[TB] FAIL timeout_done_wins got=%h want=%h", obsVec(), expVec(3'd5));
        end
        vectors++;
    endtask
`else
    task automatic test_no_timeout();
        drive(1, 8'h0A, 0, 0, 8'h00);
        mA = 8'h0A; mValid = 1'b0;
        drive(1, 8'h0B, 0, 0, 8'h00);
        mB = 8'h0B;
        drive(1, 8'h0C, 0, 0, 8'h00);
        mOp = 8'h0C;
        drive(0, 8'h00, 0, 0, 8'h00);
        for (int i = 0; i < 300; i++) drive(0, 8'h00, 0, 0, 8'h00);
        if (obsVec() !== expVec(3'd4)) begin
            miscompares++;
            $display("[TB] FAIL no_timeout_wait got=%h want=%h", obsVec(), expVec(3'd4));
        end
        vectors++;
        drive(0, 8'h00, 0, 1, 8'h3C);
        mRes = 8'h3C; mValid = 1'b1;
        if (obsVec() !== expVec(3'd5)) begin
            miscompares++;
            $display("[TB] FAIL no_timeout_done got=%h want=%h", obsVec(), expVec(3'd5));
        end
        vectors++;
    endtask
`endif

    task automatic test_reset_mid_wait();
        int s0;
        drive(1, 8'h11, 0, 0, 8'h00);
        drive(1, 8'h22, 0, 0, 8'h00);
        drive(1, 8'h33, 0, 0, 8'h00);
        drive(0, 8'h00, 0, 0, 8'h00);
        drive(0, 8'h00, 0, 0, 8'h00);
        #1;
        reset_n = 1'b0;
        #1;
        mA = 8'h00; mB = 8'h00; mOp = 8'h00; mRes = 8'h00; mValid = 1'b0;
        if (obsVec() !== expVec(3'd0)) begin
            miscompares++;
            $display("[TB] FAIL reset_async_wait got=%h want=%h", obsVec(), expVec(3'd0));
        end
        vectors++;
        s0 = startCount;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        drive(0, 8'h00, 0, 1, 8'h99);
        if (obsVec() !== expVec(3'd0)) begin
            miscompares++;
            $display("[TB] FAIL reset_after_release got=%h want=%h", obsVec(), expVec(3'd0));
        end
        vectors++;
        if (startCount !== s0) begin
            miscompares++;
            $display("[TB] FAIL reset_no_start got=%0d want=%0d", startCount, s0);
        end
        vectors++;
    endtask

    task automatic test_random();
        logic [7:0] vals[3];
        logic [7:0] res;
        logic [2:0] cur;
        int abortAt;
        int delay;
        int gap;
        bit aborted;
        cur = 3'd0;
        for (int n = 0; n < 40; n++) begin
            for (int k = 0; k < 3; k++) vals[k] = 8'($urandom);
            res = 8'($urandom);
            delay = $urandom_range(0, 3);
            abortAt = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : 4;
            aborted = 1'b0;
            for (int k = 0; k < 3 && !aborted; k++) begin
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) begin
                    drive(0, 8'($urandom), 0, 1'($urandom), 8'($urandom));
                    if (obsVec() !== expVec(cur)) begin
                        miscompares++;
                        $display("[TB] FAIL rand%0d_gap got=%h want=%h", n, obsVec(), expVec(cur));
                    end
                    vectors++;
                end
                if (abortAt == k) begin
                    drive(1'($urandom), 8'($urandom), 1, 1'($urandom), 8'($urandom));
                    cur = 3'd0;
                    mValid = 1'b0;
                    aborted = 1'b1;
                end else begin
                    drive(1, vals[k], 0, 1'($urandom), 8'($urandom));
                    case (k)
                        0: begin mA = vals[0]; mValid = 1'b0; end
                        1: mB = vals[1];
                        default: mOp = vals[2];
                    endcase
                    cur = 3'(k + 1);
                end
                if (obsVec() !== expVec(cur)) begin
                    miscompares++;
                    $display("[TB] FAIL rand%0d_load%0d got=%h want=%h", n, k, obsVec(), expVec(cur));
                end
                vectors++;
            end
            if (!aborted) begin
                drive(1'($urandom), 8'($urandom), 0, 1'($urandom), 8'($urandom));
                cur = 3'd4;
                if (obsVec() !== expVec(cur)) begin
                    miscompares++;
                    $display("[TB] FAIL rand%0d_enter_wait got=%h want=%h", n, obsVec(), expVec(cur));
                end
                vectors++;
                for (int w = 0; w < delay; w++) begin
                    drive(1'($urandom), 8'($urandom), 0, 0, 8'($urandom));
                    if (obsVec() !== expVec(cur)) begin
                        miscompares++;
                        $display("[TB] FAIL rand%0d_wait%0d got=%h want=%h", n, w, obsVec(), expVec(cur));
                    end
                    vectors++;
                end
                if (abortAt == 3) begin
                    drive(1'($urandom), 8'($urandom), 1, 1, res);
                    cur = 3'd0;
                    mValid = 1'b0;
                end else begin
                    drive(1'($urandom), 8'($urandom), 0, 1, res);
                    mRes = res;
                    mValid = 1'b1;
                    cur = 3'd5;
                end
                if (obsVec() !== expVec(cur)) begin
                    miscompares++;
                    $display("[TB] FAIL rand%0d_finish got=%h want=%h", n, obsVec(), expVec(cur));
                end
                vectors++;
            end
        end
    endtask

    initial begin
        $display("[TB] ula_sequencer bench starting");
        test_reset();
        test_normal_op();
        test_chaining();
        test_abort();
        test_spurious_done();
`ifdef ULA_SEQ_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_mid_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ula_sequencer.md
# ula_sequencer

Control FSM that sequences the 8-bit ULA for the switch-driven processor. It captures operand A, operand B and the opcode from the shared 8-bit switch bus on successive load strobes, then issues a single-cycle start to the ULA. It waits for the ULA's done handshake, latches the result for display, and exposes its state for LED debug. It sits between the debounced KEY/SW inputs and the ULA and replaces ad-hoc selector-driven register loading.

## Interface
- TIMEOUT_CYCLES, 200: cycles allowed in WAIT before error; used only with the timeout macro; range 1..255.
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- data_in  in  8  operand/opcode value from the switches.
- load  in  1  single-cycle load strobe, already debounced and edge-detected.
- abort  in  1  single-cycle abort strobe.
- ula_done  in  1  ULA result-ready pulse.
- ula_result  in  8  ULA result, valid while ula_done=1.
- reg_a  out  8  operand A to ULA.
- reg_b  out  8  operand B to ULA.
- opcode  out  8  opcode to ULA.
- ula_start  out  1  one-cycle start pulse to ULA.
- result  out  8  latched ULA result.
- result_valid  out  1  result holds a completed operation.
- busy  out  1  high in START or WAIT.
- state  out  3  current FSM encoding, for LEDR.
- error  out  1  timeout flag; constant 0 without the macro.

Clock and reset: one clock, `clock`; asynchronous active-low reset, `reset_n`.

## Operation
- States and encodings: IDLE=0, GET_B=1, GET_OP=2, START=3, WAIT=4, DONE=5, ERR=6.
- IDLE: on load, reg_a<=data_in and go to GET_B.
- GET_B: on load, reg_b<=data_in and go to GET_OP.
- GET_OP: on load, opcode<=data_in and go to START.
- START: ula_start=1 for exactly this cycle. Go to WAIT unconditionally. Clear the timeout counter. load is ignored.
- WAIT: on ula_done, result<=ula_result, result_valid<=1, go to DONE. load is ignored.
- DONE: result and result_valid hold. On load, reg_a<=data_in, result_valid<=0, go to GET_B. This chains the next operation.
- ERR: error=1. On load, error<=0 and go to IDLE; nothing is captured.
- abort in any state: go to IDLE next edge and clear result_valid and error. reg_a, reg_b, opcode and result keep their values. abort beats load in the same cycle.
- ula_done outside WAIT is ignored.
- busy = (state==START) or (state==WAIT). Outputs are Moore-derived from registered state.

## Timing
- Reset values: state=IDLE(0). reg_a, reg_b, opcode and result are 0x00. ula_start, result_valid, busy and error are 0. The counter is 0.
- Reset mid-operation, including in WAIT, takes effect immediately and asynchronously.
- Capture latency: a register updates on the edge where load=1. The state advances on the same edge.
- ula_start is high the cycle after the opcode-capturing load, for exactly 1 cycle.
- result and result_valid update on the edge where ula_done=1 is sampled in WAIT. They are visible the following cycle.
- Minimum op latency, load(opcode) to result_valid: 3 edges when ULA done arrives in the first WAIT cycle.
- Timeout (macro on): the counter increments each WAIT cycle without ula_done. When the counter reaches TIMEOUT_CYCLES, go to ERR next edge.
- ula_done in the same cycle the timeout is reached: done wins, go to DONE.

## Configuration
- ULA_SEQ_TIMEOUT_EN defined: the WAIT watchdog, counter and ERR state are compiled in. error behaves as above.
- ULA_SEQ_TIMEOUT_EN undefined: WAIT waits indefinitely for ula_done. The counter is removed, ERR is unreachable, and error is tied to 0. The TIMEOUT_CYCLES parameter is unused.

## Test plan
- Reset: assert reset_n=0 mid-WAIT -> state=0, all outputs 0, ula_start never pulses.
- Normal op: load 0x12, 0x34, 0x01, then ULA done with 0x46 two cycles after start -> reg_a=0x12, reg_b=0x34, opcode=0x01, one ula_start pulse, result=0x46, result_valid=1, state=5.
- Chaining: from DONE, load 0x05 -> reg_a=0x05, result_valid=0, state=1. A load held during START or WAIT causes no register change.
- Abort priority: in GET_OP, assert abort and load together with data_in 0xFF -> state=0, opcode unchanged, result_valid=0.
- Timeout (macro on, TIMEOUT_CYCLES=4): never assert ula_done -> state=6 and error=1 after 4 WAIT cycles. A later load gives state=0 and error=0. Done on the 4th cycle instead -> DONE, error=0.
- Spurious done: pulse ula_done with 0xAA in IDLE -> result and result_valid unchanged.
